// File: rtl/packet_framer.sv
// Packet prefixer: wraps input beats with a prefix, a payload-length trailer and alignment pad,
// buffering words in a circular buffer that is drained OUTPUT_WORDS at a time.
module packet_framer #(
    parameter int unsigned WORD_SIZE    = 8,
    parameter int unsigned INPUT_WORDS  = 4,
    parameter int unsigned OUTPUT_WORDS = 2,
    parameter int unsigned PREFIX_WORDS = 3,
    parameter int unsigned LEN_WORDS    = 2,
    parameter int unsigned PAD_WORD     = 0,
    parameter int unsigned BUFFER_SIZE  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 in_full,
    input  logic                                 in_shift,
    input  logic [WORD_SIZE*INPUT_WORDS-1:0]     in_data,
    input  logic [WORD_SIZE*PREFIX_WORDS-1:0]    in_prefix,
    input  logic                                 in_start,
    input  logic                                 in_end,
    input  logic                                 out_pop,
    output logic                                 out_nempty,
    output logic [WORD_SIZE*OUTPUT_WORDS-1:0]    out_data,
    output logic [$clog2(BUFFER_SIZE):0]         out_level
);

    localparam int unsigned PTR_W  = $clog2(BUFFER_SIZE);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned MAX_WR = INPUT_WORDS + PREFIX_WORDS + LEN_WORDS + OUTPUT_WORDS - 1;
    localparam int unsigned CNT_W  = WORD_SIZE * ((LEN_WORDS > 0) ? LEN_WORDS : 1);
    localparam int unsigned FLAT_W = CNT_W + WORD_SIZE * (INPUT_WORDS + PREFIX_WORDS);
    localparam int unsigned SEQ_W  = MAX_WR * WORD_SIZE;

    logic [WORD_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [LVL_W-1:0]     level;
    logic [CNT_W-1:0]     cnt;

    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     cnt_next;
    logic [FLAT_W-1:0]    flat;
    logic [SEQ_W-1:0]     seq;
    logic [LVL_W-1:0]     pre_n;
    logic [LVL_W-1:0]     len_end;
    logic [LVL_W-1:0]     misal;
    logic [LVL_W-1:0]     pad_n;
    logic [LVL_W-1:0]     n_wr;

    // Back-pressure leaves room for the largest possible single-beat write.
    assign in_full    = (LVL_W'(BUFFER_SIZE) - level) < LVL_W'(MAX_WR);
    assign out_nempty = level >= LVL_W'(OUTPUT_WORDS);
    assign out_level  = level;
    assign push       = in_shift && !in_full;
    assign pop        = out_pop && out_nempty;
    assign cnt_next   = in_start ? CNT_W'(INPUT_WORDS) : cnt + CNT_W'(INPUT_WORDS);

    // Word sequence for this beat: prefix, payload, trailer; prefix dropped by shifting when absent.
    always_comb begin
        flat    = {cnt_next, in_data, in_prefix};
        seq     = in_start ? SEQ_W'(flat) : SEQ_W'(flat >> (PREFIX_WORDS * WORD_SIZE));
        pre_n   = in_start ? LVL_W'(PREFIX_WORDS) : '0;
        len_end = pre_n + LVL_W'(INPUT_WORDS) + (in_end ? LVL_W'(LEN_WORDS) : '0);
        misal   = (LVL_W'(wptr) + len_end) % LVL_W'(OUTPUT_WORDS);
        pad_n   = (in_end && misal != '0) ? LVL_W'(OUTPUT_WORDS) - misal : '0;
        n_wr    = len_end + pad_n;
    end

    // Buffer storage; contents need no reset because pointers and level gate visibility.
    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(MAX_WR); j++) begin
            if (!rst && push && LVL_W'(j) < n_wr) begin
                mem[wptr + PTR_W'(j)] <= (LVL_W'(j) < len_end) ? seq[j*WORD_SIZE +: WORD_SIZE]
                                                                : WORD_SIZE'(PAD_WORD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(n_wr);
                cnt  <= in_end ? '0 : cnt_next;
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(OUTPUT_WORDS);
            end
            level <= level + (push ? n_wr : '0) - (pop ? LVL_W'(OUTPUT_WORDS) : '0);
        end
    end

    // Show-ahead read of the oldest output word.
    always_comb begin
        out_data = '0;
        if (out_nempty) begin
            for (int k = 0; k < int'(OUTPUT_WORDS); k++) begin
                out_data[k*WORD_SIZE +: WORD_SIZE] = mem[rptr + PTR_W'(k)];
            end
        end
    end

endmodule
